// File: rtl/datamem_lsu_if.sv
// Request/response bus between a load/store requester and datamem_lsu.
// The requester drives the request fields and resp_ready. The LSU drives
// req_ready and the response fields.
interface datamem_lsu_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_lsu.sv
// Single-port word-organised data memory with a RISC-V style load/store unit.
// An access is accepted in IDLE. The array is read or written on the
// acceptance edge. The formatted response is held in RESP until the consumer
// takes it, which gives at most one access every two cycles.
module datamem_lsu #(
  parameter int ADDR_W        = 9,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  datamem_lsu_if.slave  bus
);
  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  // Response context captured at acceptance
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic        we_q;

  // Request decode
  logic              accept;
  logic              legal;
  logic              misaligned;
  logic              err;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       fmt;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Decode size, legality, alignment, effective lane and byte enables
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    legal      = 1'b0;
    misaligned = 1'b0;
    lane       = bus.req_addr[1:0];
    be         = 4'b0000;
    wlanes     = bus.req_wdata;
    widx       = bus.req_addr[ADDR_W-1:2];
    if (bus.req_we) legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else            legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    unique case (bus.req_funct3[1:0])
      2'b01: begin
        misaligned = bus.req_addr[0];
        lane       = {bus.req_addr[1], 1'b0};
        be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes     = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (bus.req_addr[1:0] != 2'b00);
        lane       = 2'b00;
        be         = 4'b1111;
      end
      default: begin
        be     = 4'b0001 << bus.req_addr[1:0];
        wlanes = {4{bus.req_wdata[7:0]}};
      end
    endcase
    err    = !legal || (MISALIGN_TRAP && misaligned);
    accept = (state_q == IDLE) && bus.req_valid && !rst;
  end

  // State register and response context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q   <= bus.req_funct3;
        lane_q <= lane;
        err_q  <= err;
        we_q   <= bus.req_we;
      end
    end
  end

  // Memory array: byte-enabled write and registered word read on acceptance
  // NOTE: the array holds data, not control, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word <= mem[widx];
      if (bus.req_we && !err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load formatting from the captured word; stores and errors return zero
  always_comb begin
    byte_sel = rd_word[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    fmt      = 32'h0;
    unique case (f3_q)
      3'b000:  fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
      3'b010:  fmt = rd_word;
      3'b100:  fmt = {24'h0, byte_sel};
      3'b101:  fmt = {16'h0, half_sel};
      default: fmt = 32'h0;
    endcase
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? fmt : 32'h0;
  end
endmodule

// File: tb/tb_datamem_lsu.sv
// Directed bench for datamem_lsu. Two instances run in lockstep: one traps
// misaligned accesses and one rounds them down. The vector table drives
// both instances and holds the expected response for each.
module tb_datamem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  datamem_lsu_if #(.ADDR_W(9)) bus1 ();
  datamem_lsu_if #(.ADDR_W(9)) bus0 ();

  datamem_lsu #(.ADDR_W(9), .MISALIGN_TRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  datamem_lsu #(.ADDR_W(9), .MISALIGN_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd1;
    logic        e1;
    logic [31:0] rd0;
    logic        e0;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] wdata);
    bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
    bus1.req_addr = addr; bus1.req_wdata = wdata;
    bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
    bus0.req_addr = addr; bus0.req_wdata = wdata;
  endtask

  task automatic set_rr(input logic r);
    bus1.resp_ready = r;
    bus0.resp_ready = r;
  endtask

  // One full access on both instances, with a latency-1 check on the response
  task automatic access(input string name, input logic we, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd1, output logic e1,
                        output logic [31:0] rd0, output logic e0);
    @(negedge clk);
    drive(1'b1, we, f3, addr, wdata);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    @(negedge clk);
    check({name, " valid1"}, 32'(bus1.resp_valid), 32'd1);
    check({name, " valid0"}, 32'(bus0.resp_valid), 32'd1);
    rd1 = bus1.resp_rdata; e1 = bus1.resp_err;
    rd0 = bus0.resp_rdata; e0 = bus0.resp_err;
    set_rr(1'b1);
    @(posedge clk);
    #1 set_rr(1'b0);
  endtask

  initial begin
    logic [31:0] rd1, rd0, hold;
    logic        e1, e0;

    vecs.push_back('{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 9'h011, 32'h0000007F, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD7FEF, 1'b0, 32'hDEAD7FEF, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 9'h013, 32'h0,        32'h000000DE, 1'b0, 32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 9'h012, 32'h0,        32'hFFFFFFAD, 1'b0, 32'hFFFFFFAD, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 9'h010, 32'h0,        32'h00007FEF, 1'b0, 32'h00007FEF, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 9'h012, 32'h0,        32'h0000DEAD, 1'b0, 32'h0000DEAD, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 9'h020, 32'h11223344, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'b001, 9'h022, 32'h00008001, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b001, 9'h022, 32'h0,        32'hFFFF8001, 1'b0, 32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 9'h022, 32'h0,        32'h00008001, 1'b0, 32'h00008001, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h020, 32'h0,        32'h80013344, 1'b0, 32'h80013344, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 9'h020, 32'h0,        32'h00000044, 1'b0, 32'h00000044, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 9'h030, 32'h00000000, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'b010, 9'h031, 32'h12345678, 32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h030, 32'h0,        32'h00000000, 1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h032, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 9'h021, 32'h0,        32'h0,        1'b1, 32'h00003344, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 9'h023, 32'h0000BEEF, 32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 9'h020, 32'h0,        32'h80013344, 1'b0, 32'hBEEF3344, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 9'h010, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b110, 9'h010, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b011, 9'h010, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b100, 9'h010, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD7FEF, 1'b0, 32'hDEAD7FEF, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 9'h1FF, 32'h000000A5, 32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b100, 9'h1FF, 32'h0,        32'h000000A5, 1'b0, 32'h000000A5, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 9'h1FF, 32'h0,        32'hFFFFFFA5, 1'b0, 32'hFFFFFFA5, 1'b0});

    // Reset state
    drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    set_rr(1'b0);
    #12;
    check("rst req_ready",  32'(bus1.req_ready),  32'd1);
    check("rst resp_valid", 32'(bus1.resp_valid), 32'd0);
    check("rst resp_rdata", bus1.resp_rdata,      32'h0);
    check("rst resp_err",   32'(bus1.resp_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven accesses
    foreach (vecs[i]) begin
      access($sformatf("v%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             rd1, e1, rd0, e0);
      check($sformatf("v%0d rdata trap", i),  rd1,     vecs[i].rd1);
      check($sformatf("v%0d err trap", i),    32'(e1), 32'(vecs[i].e1));
      check($sformatf("v%0d rdata round", i), rd0,     vecs[i].rd0);
      check($sformatf("v%0d err round", i),   32'(e0), 32'(vecs[i].e0));
    end

    // Back-pressure: response held 5 cycles while a second request is ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 3'b010, 9'h010, 32'h0);
    hold = 32'hDEAD7FEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid", c),     32'(bus1.resp_valid), 32'd1);
      check($sformatf("stall%0d rdata", c),     bus1.resp_rdata,      hold);
      check($sformatf("stall%0d err", c),       32'(bus1.resp_err),   32'd0);
      check($sformatf("stall%0d req_ready", c), 32'(bus1.req_ready),  32'd0);
    end
    drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    set_rr(1'b1);
    @(posedge clk);
    #1 set_rr(1'b0);

    // resp_ready while idle has no effect
    @(negedge clk);
    set_rr(1'b1);
    @(negedge clk);
    check("idle rr valid", 32'(bus1.resp_valid), 32'd0);
    check("idle rr ready", 32'(bus1.req_ready),  32'd1);
    set_rr(1'b0);
    access("after stall", 1'b0, 3'b010, 9'h010, 32'h0, rd1, e1, rd0, e0);
    check("stalled store ignored", rd1, 32'hDEAD7FEF);

    // Reset mid-cycle while in RESP after a store
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 9'h040, 32'hCAFEF00D);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst valid", 32'(bus1.resp_valid), 32'd0);
    check("midrst ready", 32'(bus1.req_ready),  32'd1);
    check("midrst rdata", bus1.resp_rdata,      32'h0);
    check("midrst err",   32'(bus1.resp_err),   32'd0);
    // A request presented across an edge with rst high is not accepted
    drive(1'b1, 1'b1, 3'b010, 9'h040, 32'h00000001);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst no accept", 32'(bus1.resp_valid), 32'd0);
    access("post rst", 1'b0, 3'b010, 9'h040, 32'h0, rd1, e1, rd0, e0);
    check("store survives rst trap",  rd1, 32'hCAFEF00D);
    check("store survives rst round", rd0, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamem_lsu.md
DATAMEM_LSU -- requirements
Module: datamem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width; memory depth is 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter MISALIGN_TRAP, default 1:
- 1: misaligned access returns an error.
- 0: misaligned address is rounded down to the access size.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 access size/sign.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts response.
REQ-013 resp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal access.

Function
REQ-015 SHALL implement an FSM with two states:
- IDLE: req_ready=1.
- RESP: resp_valid=1, req_ready=0.
REQ-016 A request is accepted on a clock edge where state=IDLE and req_valid=1; the state then becomes RESP.
REQ-017 In RESP, the state SHALL return to IDLE on the edge where resp_ready=1.
- resp_rdata and resp_err SHALL hold stable until that edge.
- Maximum throughput is one access per 2 cycles.
REQ-018 Loads:
- The array word at req_addr[ADDR_W-1:2] is captured at the acceptance edge.
- Formatted data appears on resp_rdata in the next cycle (latency 1).
REQ-019 Stores:
- The array is written at the acceptance edge, using byte enables only.
- Untouched byte lanes SHALL keep their previous value.
REQ-020 Memory is little-endian; byte lane L = addr[1:0] maps to word bits [8L+7:8L].
REQ-021 Load formatting:
- 000 LB: lane L, sign-extended.
- 001 LH: half at addr[1], sign-extended.
- 010 LW: full word.
- 100 LBU: lane L, zero-extended.
- 101 LHU: half at addr[1], zero-extended.
REQ-022 Store lane placement:
- 000 SB: wdata[7:0] written to lane L only.
- 001 SH: wdata[15:0] written to lanes {2*addr[1], 2*addr[1]+1}.
- 010 SW: all four lanes.
REQ-023 Illegal funct3 (load 011/110/111; store anything except 000/001/010):
- resp_err=1 and resp_rdata=0.
- No array write.
REQ-024 Misalignment is defined as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-025 With MISALIGN_TRAP=1, a misaligned access SHALL give resp_err=1 and resp_rdata=0, with no array write.
REQ-026 With MISALIGN_TRAP=0, a misaligned access SHALL execute at the address rounded down (addr[0] cleared for halfwords, addr[1:0] cleared for words), with resp_err=0.
REQ-027 Requests presented while in RESP SHALL be ignored; the requester must hold req_valid until req_ready.
REQ-028 resp_ready asserted while in IDLE SHALL have no effect.

Reset
REQ-029 On rst=1, immediately and independent of clk:
- State becomes IDLE, giving req_ready=1.
- resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Array contents SHALL NOT be reset.
REQ-031 Reset during RESP SHALL drop the pending response; a store already accepted remains written.
REQ-032 No request SHALL be accepted on an edge where rst=1.

Verification
REQ-033 SW 0xDEADBEEF @0x010, then LW @0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid one cycle after acceptance.
REQ-034 After REQ-033: SB 0x7F @0x011, then LW @0x010 -> 0xDEAD7FEF; then LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE.
REQ-035 SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU @0x022 -> 0x00008001; LW @0x020 -> upper half 0x8001, lower half unchanged.
REQ-036 MISALIGN_TRAP=1: SW 0x12345678 @0x031 -> resp_err=1, resp_rdata=0, word 0x030 unchanged. MISALIGN_TRAP=0: same store -> resp_err=0 and word 0x030 = 0x12345678.
REQ-037 Hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stable, req_ready=0; a second req_valid during this time is not accepted.
REQ-038 Assert rst mid-cycle while in RESP -> resp_valid=0 and req_ready=1 immediately; a prior store is still readable afterwards.
